// File: rtl/core_pkg.sv
// Shared core types for the register writeback path.
package core_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    WB_NORMAL,
    WB_STARVED
  } wb_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_writeback_if.sv
// Writeback bus: ALU/LSU sources in, register file write port out.
// WB_PENDING_EN adds the pending_mask signal.
interface reg_writeback_if;
  import core_pkg::*;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_addr;
  logic [REG_DATA_W-1:0] alu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [REG_ADDR_W-1:0] lsu_addr;
  logic [REG_DATA_W-1:0] lsu_data;
  logic                  write_enable;
  logic [REG_ADDR_W-1:0] write_addr;
  logic [REG_DATA_W-1:0] write_data;
  logic                  stall_req;
  logic                  fifo_empty;
`ifdef WB_PENDING_EN
  logic [NUM_REGS-1:0]   pending_mask;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output lsu_valid, lsu_addr, lsu_data,
    input  lsu_ready, write_enable, write_addr,
    input  write_data, stall_req, fifo_empty,
    input  pending_mask
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  lsu_valid, lsu_addr, lsu_data,
    output lsu_ready, write_enable, write_addr,
    output write_data, stall_req, fifo_empty,
    output pending_mask
  );
`else
  modport master (
    output alu_valid, alu_addr, alu_data,
    output lsu_valid, lsu_addr, lsu_data,
    input  lsu_ready, write_enable, write_addr,
    input  write_data, stall_req, fifo_empty
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  lsu_valid, lsu_addr, lsu_data,
    output lsu_ready, write_enable, write_addr,
    output write_data, stall_req, fifo_empty
  );
`endif
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; caller gates push/pop
// with full/empty.
module wb_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wb_entry_t     push_entry,
  input  logic          pop,
  output wb_entry_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/reg_writeback.sv
// Register file write arbiter: ALU always wins, LSU results buffered.
// Optional WB_PENDING_EN adds a per-register pending mask.
module reg_writeback
  import core_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  reg_writeback_if.slave  wb
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  wb_entry_t     head;
  wb_entry_t     lsu_entry;

  logic          we_q;
  wb_entry_t     wr_q;
  wb_state_t     state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          starve;

  assign lsu_entry = '{addr: wb.lsu_addr, data: wb.lsu_data};
  assign push = wb.lsu_valid && !full;
  assign pop  = !wb.alu_valid && !empty;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (lsu_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  assign wb.lsu_ready    = !full;
  assign wb.fifo_empty   = empty;
  assign wb.write_enable = we_q;
  assign wb.write_addr   = wr_q.addr;
  assign wb.write_data   = wr_q.data;
  assign wb.stall_req    = state_q == WB_STARVED;

  // r0 winners still consume their slot but never reach the file
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      wr_q <= '0;
    end else if (wb.alu_valid) begin
      we_q <= |wb.alu_addr;
      wr_q <= '{addr: wb.alu_addr, data: wb.alu_data};
    end else if (pop) begin
      we_q <= |head.addr;
      wr_q <= head;
    end else begin
      we_q <= 1'b0;
    end
  end

  assign starve = !empty && wb.alu_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WB_NORMAL: begin
        if (!starve) begin
          cnt_d = '0;
        end else if (cnt_q == SW'(STARVE_LIMIT - 1)) begin
          cnt_d   = '0;
          state_d = WB_STARVED;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      WB_STARVED: begin
        cnt_d = '0;
        if (empty) state_d = WB_NORMAL;
      end
      default: begin
        cnt_d   = '0;
        state_d = WB_NORMAL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WB_NORMAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef WB_PENDING_EN
  logic [NUM_REGS-1:0] mask;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_pend
    logic [CW-1:0] pend_cnt;
    logic          inc;
    logic          dec;

    assign inc = push && wb.lsu_addr == REG_ADDR_W'(k);
    assign dec = pop && head.addr == REG_ADDR_W'(k);

    always_ff @(posedge clk) begin
      if (rst) begin
        pend_cnt <= '0;
      end else if (inc && !dec) begin
        pend_cnt <= pend_cnt + CW'(1);
      end else if (dec && !inc) begin
        pend_cnt <= pend_cnt - CW'(1);
      end
    end

    if (k == 0) begin : g_r0
      assign mask[k] = 1'b0;
    end else begin : g_rn
      assign mask[k] = |pend_cnt;
    end
  end

  assign wb.pending_mask = mask;
`endif
endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-side arbiter and buffer sitting in front of the CPU core's 32x32 register file.
- Merges two writeback sources into the register file's single write port:
  - single-cycle ALU results, which cannot be back-pressured;
  - long-latency load/mul-div results, which use a valid/ready handshake and are buffered in a small FIFO.
- Drives the register file's write_enable/write_addr/write_data through one registered stage.
- Raises a stall request when buffered results starve.

Parameters:
- FIFO_DEPTH, 4, entries in the long-latency result FIFO (power of 2, >=2).
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may lose arbitration before stall_req asserts.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- alu_valid  input  1  ALU result present this cycle.
- alu_addr  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- lsu_valid  input  1  long-latency result offered.
- lsu_ready  output  1  FIFO can accept; transfer when lsu_valid && lsu_ready.
- lsu_addr  input  5  long-latency destination register.
- lsu_data  input  32  long-latency result.
- write_enable  output  1  to register file.
- write_addr  output  5  to register file.
- write_data  output  32  to register file.
- stall_req  output  1  asks the pipeline to withhold alu_valid.
- fifo_empty  output  1  no buffered long-latency results.

Behaviour:
- Reset (synchronous, active-high):
  - write_enable=0, write_addr=0, write_data=0, stall_req=0.
  - FIFO emptied: lsu_ready=1, fifo_empty=1.
  - Starve counter=0, FSM in NORMAL.
  - Reset mid-operation discards all buffered entries.
- Latency: one cycle. A winner in cycle N appears on write_* in cycle N+1 with write_enable=1. With no winner, write_enable=0 and write_addr/write_data hold their previous values.
- Arbitration each cycle:
  - alu_valid always wins.
  - Otherwise the FIFO head is popped and written.
  - alu_valid is never dropped, including while stall_req=1 (protocol violation tolerated; ALU still wins).
- r0 rule:
  - A winner with destination 0 produces write_enable=0 next cycle, but the FIFO entry is still popped.
  - LSU pushes to r0 are still accepted.
- FIFO:
  - lsu_ready = !full, combinational from registered occupancy.
  - Push on a handshake.
  - Simultaneous push and pop when full is not allowed (ready=0). When not full, push and pop in the same cycle keep the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
  - Push into an empty FIFO is not written in the same cycle. Head is first eligible one cycle later; no bypass.
- FSM:
  - NORMAL: starve counter increments each cycle the FIFO is non-empty and alu_valid=1. It clears on any pop or when the FIFO is empty. When the counter reaches STARVE_LIMIT-1 with that condition true, go to STARVED.
  - STARVED: stall_req=1 (registered). Stay until the FIFO is empty, then return to NORMAL with counter=0 and stall_req=0 on the following cycle.
  - In STARVED the FIFO drains one entry per cycle when alu_valid=0.
- Ordering:
  - LSU results are written in acceptance order.
  - An ALU write and a pending FIFO entry to the same register are not reordered or merged; the later actual write wins. Hazard avoidance is the issue logic's job.

Optional Feature:
- Macro WB_PENDING_EN.
- When defined:
  - Adds output pending_mask [31:0]. Bit k is set while any FIFO entry targets register k.
  - The mask is maintained with a per-register count of entries. Set on push, decremented on pop; bit 0 is forced to 0.
  - Used by issue logic to stall on RAW against buffered loads.
- When undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (core_pkg):
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32.
  - wb_state_t enum {WB_NORMAL, WB_STARVED}.
  - wb_entry_t struct {addr, data}.
- One natural sub-module: wb_fifo, a synchronous FIFO of wb_entry_t with push/pop/full/empty/count.

Test Plan:
- Reset, then alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF for one cycle -> next cycle write_enable=1, write_addr=5, write_data=0xDEADBEEF; the cycle after, write_enable=0.
- Push LSU {addr 3, 0x11} while alu_valid=0 -> accepted; written two cycles after the handshake; fifo_empty returns to 1.
- Push 4 LSU entries with alu_valid held 1 -> lsu_ready=0 after the 4th. stall_req=1 after 8 starved cycles. Dropping alu_valid drains addresses in push order, one per cycle. stall_req=0 the cycle after empty.
- ALU write to r0 and LSU entry to r0 -> write_enable stays 0; FIFO pops normally.
- Fill 3 entries, assert rst for one cycle -> fifo_empty=1, lsu_ready=1, write_enable=0, stall_req=0; no stale entry is ever written.
- With WB_PENDING_EN: push two entries to r7 -> pending_mask[7]=1 until the second pops, then 0.
